gem_roll_wg_lut_sched: RTL and testbench

- Schedules the shared GEM-roll-to-CSC-wiregroup LUT (8 entries; odd/even chamber tables; low/high wiregroup read ports; 1-cycle registered read).
- Per BX, serialises up to NCLU GEM cluster roll lookups through the single LUT read path and returns the wiregroup window of each cluster, tagged with its index.
- Also arbitrates VME LUT reprogramming writes, so that a write never overlaps an in-flight read.

---
 rtl/gem_roll_wg_lut_sched.sv | 208 ++++++++++++++++++++
 tb/tb_gem_roll_wg_lut_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_roll_wg_lut_sched.sv
`default_nettype none
// ============================================================================
// Module      : gem_roll_wg_lut_sched
// Description : Serialises per-BX GEM cluster roll lookups through the shared
//               roll-to-wiregroup LUT read path, returns each cluster's
//               wiregroup window tagged with its index, and slots VME LUT
//               writes in only when no read is issued or in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module gem_roll_wg_lut_sched #(
    parameter int NCLU = 8,
    parameter int IDXW = 3
) (
    input  logic                clock,
    input  logic                global_reset_n,
    input  logic                bx_start,
    input  logic [NCLU-1:0]     clu_vld,
    input  logic [3*NCLU-1:0]   clu_roll,
    input  logic                odd,
    input  logic                wr_req,
    input  logic [2:0]          wr_adr,
    input  logic [6:0]          wr_data,
    output logic                wr_ack,
    output logic                lut_wen,
    output logic [2:0]          lut_w_adr,
    output logic [6:0]          lut_w_data,
    output logic                lut_renodd,
    output logic                lut_reneven,
    output logic [2:0]          lut_r_adr1,
    output logic [2:0]          lut_r_adr2,
    input  logic [6:0]          lut_r_data1,
    input  logic [6:0]          lut_r_data2,
    output logic                res_vld,
    output logic [IDXW-1:0]     res_idx,
    output logic [6:0]          res_wg_lo,
    output logic [6:0]          res_wg_hi,
    output logic                bx_done,
    output logic                busy,
    output logic                overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NCLU-1:0]    r_pend;
    logic [3*NCLU-1:0]  r_roll;
    logic               r_odd;

    // Two-stage index pipe aligned with the LUT read and its data cycle.
    logic               r_p0_vld;
    logic               r_p0_last;
    logic [IDXW-1:0]    r_p0_idx;
    logic               r_p1_vld;
    logic               r_p1_last;
    logic [IDXW-1:0]    r_p1_idx;

    logic               w_bx_accept;
    logic               w_bx_empty;
    logic               w_issue;
    logic               w_wr_go;
    logic [NCLU-1:0]    w_pend_src;
    logic [3*NCLU-1:0]  w_roll_src;
    logic               w_odd_src;
    logic [NCLU-1:0]    w_sel_oh;
    logic [IDXW-1:0]    w_sel_idx;
    logic [2:0]         w_sel_roll;
    logic [NCLU-1:0]    w_pend_nxt;
    logic               w_last;

    // Pick the lowest pending cluster. The first read is issued on the very
    // edge that accepts bx_start (straight from the inputs) so that the read
    // enable is already registered one cycle after bx_start.
    always_comb begin
        w_bx_accept = (r_state == S_IDLE) && bx_start && (|clu_vld);
        w_bx_empty  = (r_state == S_IDLE) && bx_start && !(|clu_vld);
        w_issue     = w_bx_accept || (r_state == S_ISSUE);
        w_pend_src  = w_bx_accept ? clu_vld  : r_pend;
        w_roll_src  = w_bx_accept ? clu_roll : r_roll;
        w_odd_src   = w_bx_accept ? odd      : r_odd;
        w_sel_oh    = '0;
        w_sel_idx   = '0;
        w_sel_roll  = '0;
        for (int i = NCLU - 1; i >= 0; i--) begin
            if (w_pend_src[i]) begin
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_idx   = IDXW'(i);
                w_sel_roll  = w_roll_src[3*i +: 3];
            end
        end
        w_pend_nxt  = w_pend_src & ~w_sel_oh;
        w_last      = (w_pend_nxt == '0);
        w_wr_go     = (r_state == S_IDLE) && !bx_start && wr_req;
    end

    // Next-state logic; bx_start takes priority over a pending write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_bx_accept)
                    w_state_nxt = w_last ? S_DRAIN : S_ISSUE;
                else if (w_wr_go)
                    w_state_nxt = S_WRITE;
            end
            S_ISSUE: begin
                if (w_last)
                    w_state_nxt = S_DRAIN;
            end
            // bx_done is registered together with the last result.
            S_DRAIN: begin
                if (bx_done)
                    w_state_nxt = S_IDLE;
            end
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!global_reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // BX context: pending mask, latched rolls and chamber parity.
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            r_pend <= '0;
            r_roll <= '0;
            r_odd  <= 1'b0;
        end else begin
            if (w_issue)
                r_pend <= w_pend_nxt;
            if (w_bx_accept) begin
                r_roll <= clu_roll;
                r_odd  <= odd;
            end
        end
    end

    // LUT read port, index pipe and result registers.
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            lut_renodd  <= 1'b0;
            lut_reneven <= 1'b0;
            lut_r_adr1  <= '0;
            lut_r_adr2  <= '0;
            r_p0_vld    <= 1'b0;
            r_p0_last   <= 1'b0;
            r_p0_idx    <= '0;
            r_p1_vld    <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_idx    <= '0;
            res_vld     <= 1'b0;
            res_idx     <= '0;
            res_wg_lo   <= '0;
            res_wg_hi   <= '0;
            bx_done     <= 1'b0;
        end else begin
            lut_renodd  <= w_issue && w_odd_src;
            lut_reneven <= w_issue && !w_odd_src;
            lut_r_adr1  <= w_issue ? w_sel_roll : 3'd0;
            lut_r_adr2  <= w_issue ? w_sel_roll : 3'd0;
            r_p0_vld    <= w_issue;
            r_p0_last   <= w_issue && w_last;
            r_p0_idx    <= w_issue ? w_sel_idx : '0;
            r_p1_vld    <= r_p0_vld;
            r_p1_last   <= r_p0_last;
            r_p1_idx    <= r_p0_idx;
            res_vld     <= r_p1_vld;
            res_idx     <= r_p1_vld ? r_p1_idx : '0;
            res_wg_lo   <= r_p1_vld ? lut_r_data1 : 7'd0;
            res_wg_hi   <= r_p1_vld ? lut_r_data2 : 7'd0;
            bx_done     <= (r_p1_vld && r_p1_last) || w_bx_empty;
        end
    end

    // LUT write port and status pulses.
    always_ff @(posedge clock) begin
        if (!global_reset_n) begin
            wr_ack     <= 1'b0;
            lut_wen    <= 1'b0;
            lut_w_adr  <= '0;
            lut_w_data <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_ack     <= w_wr_go;
            lut_wen    <= w_wr_go;
            lut_w_adr  <= w_wr_go ? wr_adr  : 3'd0;
            lut_w_data <= w_wr_go ? wr_data : 7'd0;
            busy       <= (w_state_nxt != S_IDLE);
            overflow   <= bx_start && (r_state != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gem_roll_wg_lut_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_gem_roll_wg_lut_sched
// Description : Scoreboard bench for gem_roll_wg_lut_sched with a behavioural
//               registered-read LUT holding a known default table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gem_roll_wg_lut_sched;

    localparam int NCLU = 8;
    localparam int IDXW = 3;

    logic                clock = 1'b0;
    logic                global_reset_n = 1'b0;
    logic                bx_start = 1'b0;
    logic [NCLU-1:0]     clu_vld = '0;
    logic [3*NCLU-1:0]   clu_roll = '0;
    logic                odd = 1'b0;
    logic                wr_req = 1'b0;
    logic [2:0]          wr_adr = '0;
    logic [6:0]          wr_data = '0;
    logic                wr_ack, lut_wen, lut_renodd, lut_reneven;
    logic [2:0]          lut_w_adr, lut_r_adr1, lut_r_adr2;
    logic [6:0]          lut_w_data;
    logic [6:0]          lut_r_data1 = '0;
    logic [6:0]          lut_r_data2 = '0;
    logic                res_vld, bx_done, busy, overflow;
    logic [IDXW-1:0]     res_idx;
    logic [6:0]          res_wg_lo, res_wg_hi;

    gem_roll_wg_lut_sched #(.NCLU(NCLU), .IDXW(IDXW)) dut (
        .clock(clock), .global_reset_n(global_reset_n), .bx_start(bx_start),
        .clu_vld(clu_vld), .clu_roll(clu_roll), .odd(odd),
        .wr_req(wr_req), .wr_adr(wr_adr), .wr_data(wr_data), .wr_ack(wr_ack),
        .lut_wen(lut_wen), .lut_w_adr(lut_w_adr), .lut_w_data(lut_w_data),
        .lut_renodd(lut_renodd), .lut_reneven(lut_reneven),
        .lut_r_adr1(lut_r_adr1), .lut_r_adr2(lut_r_adr2),
        .lut_r_data1(lut_r_data1), .lut_r_data2(lut_r_data2),
        .res_vld(res_vld), .res_idx(res_idx), .res_wg_lo(res_wg_lo),
        .res_wg_hi(res_wg_hi), .bx_done(bx_done), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Default LUT contents (odd and even chamber tables, low/high ports).
    logic [6:0] odd_lo  [8] = '{7'd40, 7'd35, 7'd27, 7'd30, 7'd20, 7'd15, 7'd11, 7'd5};
    logic [6:0] odd_hi  [8] = '{7'd50, 7'd45, 7'd38, 7'd40, 7'd30, 7'd25, 7'd19, 7'd12};
    logic [6:0] even_lo [8] = '{7'd37, 7'd33, 7'd25, 7'd21, 7'd17, 7'd12, 7'd9,  7'd6};
    logic [6:0] even_hi [8] = '{7'd47, 7'd43, 7'd35, 7'd31, 7'd27, 7'd22, 7'd18, 7'd14};

    // Behavioural LUT: one-cycle registered read; a write lands in every table.
    always @(posedge clock) begin
        if (lut_wen) begin
            odd_lo[lut_w_adr]  <= lut_w_data;
            odd_hi[lut_w_adr]  <= lut_w_data;
            even_lo[lut_w_adr] <= lut_w_data;
            even_hi[lut_w_adr] <= lut_w_data;
        end
        if (lut_renodd) begin
            lut_r_data1 <= odd_lo[lut_r_adr1];
            lut_r_data2 <= odd_hi[lut_r_adr2];
        end else if (lut_reneven) begin
            lut_r_data1 <= even_lo[lut_r_adr1];
            lut_r_data2 <= even_hi[lut_r_adr2];
        end
    end

    typedef struct { int cyc; int idx; int lo; int hi; } res_t;
    typedef struct { int cyc; int adr; int dat; } wr_t;
    res_t q_res[$];
    int   q_done[$];
    int   q_ovf[$];
    wr_t  q_wr[$];

    int n_chk  = 0;
    int n_fail = 0;
    bit exp_odd = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic ren_d1 = 1'b0, ren_d2 = 1'b0;
    always @(negedge clock) begin : mon
        res_t r;
        wr_t  w;
        int   c;
        if (res_vld) begin
            if (q_res.size() == 0) check("res_unexpected", res_vld, 0);
            else begin
                r = q_res.pop_front();
                check("res_cycle", cyc, r.cyc);
                check("res_idx", res_idx, r.idx);
                check("res_wg_lo", res_wg_lo, r.lo);
                check("res_wg_hi", res_wg_hi, r.hi);
            end
        end
        if (bx_done) begin
            if (q_done.size() == 0) check("bx_done_unexpected", bx_done, 0);
            else begin
                c = q_done.pop_front();
                check("bx_done_cycle", cyc, c);
            end
        end
        if (overflow) begin
            if (q_ovf.size() == 0) check("overflow_unexpected", overflow, 0);
            else begin
                c = q_ovf.pop_front();
                check("overflow_cycle", cyc, c);
            end
        end
        if (wr_ack) begin
            if (q_wr.size() == 0) check("wr_ack_unexpected", wr_ack, 0);
            else begin
                w = q_wr.pop_front();
                check("wr_ack_cycle", cyc, w.cyc);
                check("lut_w_adr", lut_w_adr, w.adr);
                check("lut_w_data", lut_w_data, w.dat);
            end
        end
        if (lut_renodd || lut_reneven) begin
            check("ren_odd", lut_renodd, exp_odd);
            check("ren_even", lut_reneven, !exp_odd);
        end
        check("wen_vs_read", int'(lut_wen && (lut_renodd || lut_reneven || ren_d1 || ren_d2)), 0);
        check("wen_eq_ack", lut_wen, wr_ack);
        ren_d2 = ren_d1;
        ren_d1 = lut_renodd || lut_reneven;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one bx_start and push the hand-computed results it must produce.
    task automatic issue_bx(input logic [7:0] vld, input logic [23:0] rolls, input bit odd_i,
                            input logic [55:0] elo, input logic [55:0] ehi, output int s);
        int   k;
        res_t e;
        k = 0;
        s = cyc;
        bx_start = 1'b1; clu_vld = vld; clu_roll = rolls; odd = odd_i;
        exp_odd = odd_i;
        for (int i = 0; i < 8; i++) begin
            if (vld[i]) begin
                e.cyc = s + 3 + k; e.idx = i;
                e.lo = int'(elo[7*i +: 7]); e.hi = int'(ehi[7*i +: 7]);
                q_res.push_back(e);
                k++;
            end
        end
        q_done.push_back((k == 0) ? s + 1 : s + 2 + k);
        tick();
        bx_start = 1'b0; clu_vld = '0; clu_roll = '0; odd = 1'b0;
    endtask

    task automatic wait_idle();
        int left;
        for (int i = 0; i < 40; i++) begin
            left = q_res.size() + q_done.size() + q_ovf.size() + q_wr.size();
            if (!busy && left == 0) break;
            tick();
        end
        left = q_res.size() + q_done.size() + q_ovf.size() + q_wr.size();
        if (busy || left != 0) begin
            check("idle_timeout", left + int'(busy), 0);
            q_res.delete(); q_done.delete(); q_ovf.delete(); q_wr.delete();
        end
        tick(); tick();
    endtask

    task automatic wait_ack_and_drop();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (wr_ack) begin seen = 1'b1; break; end
        end
        if (!seen) check("wr_ack_timeout", wr_ack, 1);
        tick();
        wr_req = 1'b0;
    endtask

    wr_t wtmp;

    initial begin
        int s;
        logic [23:0] ro;
        logic [55:0] lo, hi;

        repeat (3) tick();
        global_reset_n = 1'b1;
        @(negedge clock);
        check("reset_outputs", int'(|{wr_ack, lut_wen, lut_w_adr, lut_w_data, lut_renodd,
              lut_reneven, lut_r_adr1, lut_r_adr2, res_vld, res_idx, res_wg_lo, res_wg_hi,
              bx_done, busy, overflow}), 0);
        tick();

        // Odd table, clusters 0 and 2.
        ro = '0; ro[2:0] = 3'd2; ro[8:6] = 3'd6;
        lo = '0; hi = '0; lo[6:0] = 7'd27; hi[6:0] = 7'd38; lo[20:14] = 7'd11; hi[20:14] = 7'd19;
        issue_bx(8'b0000_0101, ro, 1'b1, lo, hi, s);
        wait_idle();

        // Even table, clusters 0 and 2.
        ro = '0; ro[2:0] = 3'd4; ro[8:6] = 3'd7;
        lo = '0; hi = '0; lo[6:0] = 7'd17; hi[6:0] = 7'd27; lo[20:14] = 7'd6; hi[20:14] = 7'd14;
        issue_bx(8'b0000_0101, ro, 1'b0, lo, hi, s);
        wait_idle();

        // Full BX, all rolls 0 on the even table.
        lo = '0; hi = '0;
        for (int i = 0; i < 8; i++) begin lo[7*i +: 7] = 7'd37; hi[7*i +: 7] = 7'd47; end
        issue_bx(8'hFF, 24'd0, 1'b0, lo, hi, s);
        while (cyc < s + 10) @(negedge clock);
        check("busy_at_s10", busy, 1);
        @(negedge clock);
        check("busy_at_s11", busy, 0);
        wait_idle();

        // Empty BX: immediate bx_done.
        issue_bx(8'h00, 24'd0, 1'b0, 56'd0, 56'd0, s);
        wait_idle();

        // bx_start while busy is dropped and flagged.
        ro = '0; ro[2:0] = 3'd0; ro[5:3] = 3'd4; ro[11:9] = 3'd7;
        lo = '0; hi = '0;
        lo[6:0] = 7'd37; hi[6:0] = 7'd47; lo[13:7] = 7'd17; hi[13:7] = 7'd27;
        lo[27:21] = 7'd6; hi[27:21] = 7'd14;
        issue_bx(8'b0000_1011, ro, 1'b0, lo, hi, s);
        tick();
        bx_start = 1'b1; clu_vld = 8'hFF; odd = 1'b1;
        q_ovf.push_back(s + 3);
        tick();
        bx_start = 1'b0; clu_vld = '0; odd = 1'b0;
        wait_idle();

        // Reset in the middle of a 4-cluster BX: only the first result survives.
        ro = '0; ro[2:0] = 3'd1; ro[5:3] = 3'd2; ro[8:6] = 3'd3; ro[11:9] = 3'd4;
        lo = '0; hi = '0;
        lo[6:0] = 7'd33; hi[6:0] = 7'd43; lo[13:7] = 7'd25; hi[13:7] = 7'd35;
        lo[20:14] = 7'd21; hi[20:14] = 7'd31; lo[27:21] = 7'd17; hi[27:21] = 7'd27;
        issue_bx(8'b0000_1111, ro, 1'b0, lo, hi, s);
        while (q_res.size() > 1) void'(q_res.pop_back());
        q_done.delete();
        tick(); tick();
        global_reset_n = 1'b0;
        tick();
        global_reset_n = 1'b1;
        @(negedge clock);
        check("midbx_reset_outputs", int'(|{wr_ack, lut_wen, lut_renodd, lut_reneven,
              res_vld, res_idx, res_wg_lo, res_wg_hi, bx_done, busy, overflow}), 0);
        repeat (8) tick();
        wait_idle();

        // Normal service after reset.
        ro = '0; ro[2:0] = 3'd6;
        lo = '0; hi = '0; lo[6:0] = 7'd11; hi[6:0] = 7'd19;
        issue_bx(8'b0000_0001, ro, 1'b1, lo, hi, s);
        wait_idle();

        // Write requested during a full BX waits for the BX to drain.
        lo = '0; hi = '0;
        for (int i = 0; i < 8; i++) begin lo[7*i +: 7] = 7'd37; hi[7*i +: 7] = 7'd47; end
        issue_bx(8'hFF, 24'd0, 1'b0, lo, hi, s);
        tick();
        wr_req = 1'b1; wr_adr = 3'd3; wr_data = 7'd99;
        wtmp.cyc = s + 12; wtmp.adr = 3; wtmp.dat = 99;
        q_wr.push_back(wtmp);
        wait_ack_and_drop();
        wait_idle();

        // Read back the written entry through the odd table.
        ro = '0; ro[2:0] = 3'd3;
        lo = '0; hi = '0; lo[6:0] = 7'd99; hi[6:0] = 7'd99;
        issue_bx(8'b0000_0001, ro, 1'b1, lo, hi, s);
        wait_idle();

        // Simultaneous bx_start and wr_req: BX first, write after drain.
        wr_req = 1'b1; wr_adr = 3'd1; wr_data = 7'd55;
        wtmp.cyc = cyc + 5; wtmp.adr = 1; wtmp.dat = 55;
        q_wr.push_back(wtmp);
        ro = '0; ro[2:0] = 3'd5;
        lo = '0; hi = '0; lo[6:0] = 7'd15; hi[6:0] = 7'd25;
        issue_bx(8'b0000_0001, ro, 1'b1, lo, hi, s);
        wait_ack_and_drop();
        wait_idle();

        check("leftover_queues", q_res.size() + q_done.size() + q_ovf.size() + q_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
